// File: rtl/counter_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : counter_share_pkg
//  Purpose : Shared types and default sizes for the counter-sharing arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
package counter_share_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_share_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Purpose : Combinational round-robin picker; scans from ptr+1 upward.
//  Rev     : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             valid,
    output logic [PW-1:0]    idx,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        int w_j;
        logic w_found;
        w_found = 1'b0;
        w_j     = 0;
        idx     = '0;
        onehot  = '0;
        // Offset N_REQ wraps back to ptr itself, so the last owner comes last.
        for (int k = 1; k <= N_REQ; k++) begin
            w_j = (int'(ptr) + k) % N_REQ;
            if (!w_found && req[w_j]) begin
                w_found = 1'b1;
                idx     = PW'(w_j);
            end
        end
        if (w_found)
            onehot[idx] = 1'b1;
        valid = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/counter_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : counter_share_arbiter
//  Purpose : One up-counter shared round-robin among N requesters; done pulse
//            to the owner when the counter reaches the owner's length.
//  Rev     : 1.0  initial release
// ============================================================================
module counter_share_arbiter
    import counter_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] req_len,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [CNT_W-1:0]       count,
    output logic                   upper,
    output logic                   busy
);

    localparam int PW = $clog2(N_REQ);

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_done;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_target;
    logic [PW-1:0]      r_ptr;

    logic               w_valid;
    logic [PW-1:0]      w_idx;
    logic [N_REQ-1:0]   w_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .valid  (w_valid),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    // r_ptr doubles as the owner index while RUN/DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_done   <= '0;
            r_count  <= '0;
            r_target <= '0;
            r_ptr    <= PW'(N_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_grant  <= w_onehot;
                        r_target <= req_len[int'(w_idx)*CNT_W +: CNT_W];
                        r_count  <= '0;
                        r_ptr    <= w_idx;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (!req[r_ptr]) begin
                        r_grant <= '0;
                        r_count <= '0;
                        r_state <= IDLE;
                    end else if (r_count == r_target) begin
                        r_done  <= r_grant;
                        r_state <= DONE;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_count <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_count <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign count = r_count;
    assign upper = r_count[CNT_W-1];
    assign busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_counter_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_counter_share_arbiter
//  Purpose : Directed self-checking bench for counter_share_arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_counter_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  count;
    logic        upper;
    logic        busy;

    int n_cmp;
    int n_bad;

    counter_share_arbiter #(
        .N_REQ (4),
        .CNT_W (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_len (req_len),
        .grant   (grant),
        .done    (done),
        .count   (count),
        .upper   (upper),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic [3:0] c, input logic b);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".upper"}, 32'(upper), 32'(c[3]));
        chk({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    initial begin
        logic [3:0] exp_g;
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        req     = 4'b1111;
        req_len = 16'h0000;

        // Reset dominates a full request vector.
        step();
        step();
        chk_all("reset", 4'b0000, 4'b0000, 4'd0, 1'b0);

        // Single requester, length 3; length change after grant is ignored.
        reset   = 1'b0;
        req     = 4'b0001;
        req_len = 16'h0003;
        step();
        chk_all("t2.grant", 4'b0001, 4'b0000, 4'd0, 1'b1);
        req_len = 16'h0000;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_all($sformatf("t2.cnt%0d", k), 4'b0001, 4'b0000, 4'(k), 1'b1);
        end
        step();
        chk_all("t2.done", 4'b0001, 4'b0001, 4'd3, 1'b1);
        req = 4'b0000;
        step();
        chk_all("t2.idle", 4'b0000, 4'b0000, 4'd0, 1'b0);
        step();
        chk_all("t2.stay", 4'b0000, 4'b0000, 4'd0, 1'b0);

        // All requesting, length 1; last owner was 0 so rotation starts at 1.
        req     = 4'b1111;
        req_len = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << ((1 + i) % 4);
            step();
            chk_all($sformatf("t3.g%0d", i), exp_g, 4'b0000, 4'd0, 1'b1);
            step();
            chk_all($sformatf("t3.c%0d", i), exp_g, 4'b0000, 4'd1, 1'b1);
            step();
            chk_all($sformatf("t3.d%0d", i), exp_g, exp_g, 4'd1, 1'b1);
            if (i == 4)
                req = 4'b0000;
            step();
            chk_all($sformatf("t3.i%0d", i), 4'b0000, 4'b0000, 4'd0, 1'b0);
        end

        // Full range on requester 2: no wrap, upper from 8.
        req     = 4'b0100;
        req_len = 16'h0F00;
        step();
        chk_all("t4.grant", 4'b0100, 4'b0000, 4'd0, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk_all($sformatf("t4.cnt%0d", k), 4'b0100, 4'b0000, 4'(k), 1'b1);
        end
        step();
        chk_all("t4.done", 4'b0100, 4'b0100, 4'd15, 1'b1);
        req = 4'b0000;
        step();
        chk_all("t4.idle", 4'b0000, 4'b0000, 4'd0, 1'b0);

        // Abort by requester 1 at count 2.
        req     = 4'b0010;
        req_len = 16'h0090;
        step();
        chk_all("t5.grant", 4'b0010, 4'b0000, 4'd0, 1'b1);
        step();
        step();
        chk_all("t5.cnt2", 4'b0010, 4'b0000, 4'd2, 1'b1);
        req = 4'b0000;
        step();
        chk_all("t5.abort", 4'b0000, 4'b0000, 4'd0, 1'b0);
        req     = 4'b0011;
        req_len = 16'h0097;
        step();
        chk_all("t5.regrant", 4'b0001, 4'b0000, 4'd0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_all($sformatf("t6.cnt%0d", k), 4'b0001, 4'b0000, 4'(k), 1'b1);
        end

        // Reset mid-run restores ptr so requester 0 wins first; length 0.
        reset = 1'b1;
        step();
        chk_all("t6.reset", 4'b0000, 4'b0000, 4'd0, 1'b0);
        reset   = 1'b0;
        req     = 4'b1001;
        req_len = 16'h0000;
        step();
        chk_all("t6.grant", 4'b0001, 4'b0000, 4'd0, 1'b1);
        step();
        chk_all("t6.done", 4'b0001, 4'b0001, 4'd0, 1'b1);
        step();
        chk_all("t6.idle", 4'b0000, 4'b0000, 4'd0, 1'b0);
        step();
        chk_all("t6.next", 4'b1000, 4'b0000, 4'd0, 1'b1);
        req = 4'b0000;
        step();
        chk_all("t6.abort", 4'b0000, 4'b0000, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
